// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch unit
package fetch_pkg;
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;
endpackage

// File: rtl/fetch_timeout_counter.sv
// fetch_timeout_counter: counts cycles spent waiting on imem, flags the last allowed one
module fetch_timeout_counter
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [7:0] cnt;
  // clear has priority so every new request starts from zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= 8'd0;
    else cnt <= clr ? 8'd0 : en ? cnt + 8'd1 : cnt;
  end
  assign tc = cnt == 8'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register, imem request FSM and valid/ready hand-off to decode
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0040_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic        imem_err_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [6:0]  opcode_o,
  output logic [31:0] pc_o,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        fault_o
);
  fetch_state_t state;
  logic         tmo;
  logic [31:0]  next_pc;
  fetch_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk  (clk),
    .reset(reset),
    .clr  (state != WAIT),
    .en   (state == WAIT),
    .tc   (tmo)
  );
  assign next_pc     = branch_taken_i ? branch_target_i : pc_o + PC_INC;
  assign imem_addr_o = pc_o;
  assign opcode_o    = instr_o[6:0];
  // fetch FSM with registered request/valid/fault; FAULT is terminal until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= FETCH;
      pc_o          <= RESET_PC;
      instr_o       <= NOP_INSTR;
      instr_valid_o <= 1'b0;
      imem_req_o    <= 1'b0;
      fault_o       <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          state      <= WAIT;
          imem_req_o <= 1'b1;
        end
        WAIT: begin
          if (imem_err_i || (!imem_ack_i && tmo)) begin
            state      <= FAULT;
            imem_req_o <= 1'b0;
            fault_o    <= 1'b1;
          end else if (imem_ack_i) begin
            state         <= HOLD;
            imem_req_o    <= 1'b0;
            instr_o       <= imem_rdata_i;
            instr_valid_o <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready_i) begin
            pc_o          <= next_pc;
            instr_valid_o <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              state   <= FAULT;
              fault_o <= 1'b1;
            end else begin
              state      <= WAIT;
              imem_req_o <= 1'b1;
            end
          end
        end
        FAULT: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of fetch, stall, branch, fault and wrap behaviour
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, ack, err, ready, br;
  logic [31:0] rdata, target;
  logic        req, valid, fault;
  logic [31:0] addr, instr, pc;
  logic [6:0]  opcode;
  logic        b_reset, b_ack, b_ready;
  logic [31:0] b_rdata;
  logic        b_req, b_valid, b_fault;
  logic [31:0] b_addr, b_instr, b_pc;
  logic [6:0]  b_opcode;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_err_i(err), .imem_rdata_i(rdata),
    .instr_valid_o(valid), .instr_ready_i(ready), .instr_o(instr),
    .opcode_o(opcode), .pc_o(pc), .branch_taken_i(br),
    .branch_target_i(target), .fault_o(fault)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(b_reset), .imem_req_o(b_req), .imem_addr_o(b_addr),
    .imem_ack_i(b_ack), .imem_err_i(1'b0), .imem_rdata_i(b_rdata),
    .instr_valid_o(b_valid), .instr_ready_i(b_ready), .instr_o(b_instr),
    .opcode_o(b_opcode), .pc_o(b_pc), .branch_taken_i(1'b0),
    .branch_target_i(32'h0), .fault_o(b_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; ack = 1'b0; err = 1'b0; ready = 1'b0; br = 1'b0;
    rdata = 32'h0; target = 32'h0;
    b_reset = 1'b0; b_ack = 1'b0; b_ready = 1'b0; b_rdata = 32'h0;
    tick();
    tick();
    check("rst_req", 32'(req), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_pc", pc, 32'h0040_0000);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_opcode", 32'(opcode), 32'h13);
    reset = 1'b1;
    tick();
    check("fetch_req", 32'(req), 32'd1);
    check("fetch_addr", addr, 32'h0040_0000);
    ack = 1'b1; rdata = 32'h0000_0033; ready = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_valid", 32'(valid), 32'd1);
    check("ack_opcode", 32'(opcode), 32'h33);
    check("ack_req", 32'(req), 32'd0);
    tick();
    check("next_req", 32'(req), 32'd1);
    check("next_addr", addr, 32'h0040_0004);
    check("next_valid", 32'(valid), 32'd0);
    ack = 1'b1; rdata = 32'h0000_0067; ready = 1'b0;
    tick();
    ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_instr", instr, 32'h0000_0067);
      check("stall_pc", pc, 32'h0040_0004);
      check("stall_req", 32'(req), 32'd0);
      check("stall_valid", 32'(valid), 32'd1);
      tick();
    end
    ready = 1'b1;
    tick();
    check("accept_addr", addr, 32'h0040_0008);
    check("accept_req", 32'(req), 32'd1);
    ack = 1'b1; rdata = 32'h0000_006F; br = 1'b1; target = 32'h0040_0100;
    tick();
    ack = 1'b0;
    check("br_ignored_in_wait", pc, 32'h0040_0008);
    tick();
    check("br_addr", addr, 32'h0040_0100);
    check("br_req", 32'(req), 32'd1);
    ack = 1'b1; target = 32'h0040_0102;
    tick();
    ack = 1'b0;
    tick();
    br = 1'b0;
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_pc", pc, 32'h0040_0102);
    check("mis_req", 32'(req), 32'd0);
    check("mis_valid", 32'(valid), 32'd0);
    tick();
    tick();
    check("mis_sticky_fault", 32'(fault), 32'd1);
    check("mis_sticky_req", 32'(req), 32'd0);
    ready = 1'b0;
    restart();
    check("post_fault_rst_fault", 32'(fault), 32'd0);
    check("tmo_first_wait", 32'(req), 32'd1);
    for (int i = 0; i < 15; i++) tick();
    check("tmo_wait16_req", 32'(req), 32'd1);
    check("tmo_wait16_fault", 32'(fault), 32'd0);
    tick();
    check("tmo_fault", 32'(fault), 32'd1);
    check("tmo_req", 32'(req), 32'd0);
    restart();
    ack = 1'b1; err = 1'b1; rdata = 32'h0000_0033;
    tick();
    ack = 1'b0; err = 1'b0;
    check("err_fault", 32'(fault), 32'd1);
    check("err_valid", 32'(valid), 32'd0);
    check("err_instr", instr, 32'h0000_0013);
    restart();
    tick();
    tick();
    check("midwait_req_before", 32'(req), 32'd1);
    reset = 1'b0;
    #1;
    check("midwait_async_req", 32'(req), 32'd0);
    check("midwait_async_pc", pc, 32'h0040_0000);
    tick();
    reset = 1'b1;
    tick();
    check("refetch_addr", addr, 32'h0040_0000);
    check("refetch_instr", instr, 32'h0000_0013);
    check("refetch_valid", 32'(valid), 32'd0);
    ack = 1'b1; rdata = 32'h0000_0037;
    tick();
    ack = 1'b0;
    check("refetch_opcode", 32'(opcode), 32'h37);
    b_reset = 1'b1;
    tick();
    check("wrap_first_addr", b_addr, 32'hFFFF_FFFC);
    b_ack = 1'b1; b_rdata = 32'h0000_0013; b_ready = 1'b1;
    tick();
    b_ack = 1'b0;
    check("wrap_valid", 32'(b_valid), 32'd1);
    tick();
    check("wrap_addr", b_addr, 32'h0000_0000);
    check("wrap_req", 32'(b_req), 32'd1);
    check("wrap_fault", 32'(b_fault), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the main decoder. Owns the PC register and drives a request/acknowledge instruction-memory interface. Presents each fetched instruction, its PC and its 7-bit opcode field to the decoder and execute logic through a valid/ready handshake. Accepts branch redirects resolved in the same cycle the instruction is consumed.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset (text-segment base)
TIMEOUT_CYCLES, 16, maximum wait for imem_ack_i before a fetch fault is raised (range 2..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req_o  out  1  fetch request; held high until ack or err
imem_addr_o  out  32  fetch address; equals pc_o while imem_req_o is high
imem_ack_i  in  1  memory returns imem_rdata_i this cycle
imem_err_i  in  1  bus error for the current request
imem_rdata_i  in  32  instruction word
instr_valid_o  out  1  instr_o/pc_o/opcode_o hold a valid instruction
instr_ready_i  in  1  consumer accepts the instruction this cycle
instr_o  out  32  registered instruction word
opcode_o  out  7  instr_o[6:0], feeds the decoder opcode input
pc_o  out  32  PC of the current fetch/instruction
branch_taken_i  in  1  redirect; sampled only on an accept cycle
branch_target_i  in  32  redirect target address
fault_o  out  1  sticky fetch fault (bus error, timeout or misaligned PC)

Behaviour:
- Reset (reset low, async): state=FETCH; pc_o=RESET_PC; instr_o=32'h0000_0013 (NOP); opcode_o=7'b0010011; instr_valid_o=0; imem_req_o=0; fault_o=0; timeout counter=0. imem_req_o drops immediately, mid-request included; the request is not resumed.
- States: FETCH, WAIT, HOLD, FAULT.
- FETCH: one cycle with imem_req_o=0; loads timeout counter=0; next state WAIT. This is the first state after reset release.
- WAIT: imem_req_o=1, imem_addr_o=pc_o.
  - imem_err_i=1 -> FAULT. err wins over a simultaneous ack.
  - else imem_ack_i=1 -> capture imem_rdata_i into instr_o; instr_valid_o=1 next cycle; -> HOLD.
  - else counter increments; counter reaching TIMEOUT_CYCLES-1 without ack -> FAULT.
- HOLD: instr_valid_o=1; instr_o/pc_o/opcode_o stable until accepted.
  - instr_ready_i=0 -> stay.
  - instr_ready_i=1 (accept): next_pc = branch_taken_i ? branch_target_i : pc_o+32'd4, computed mod 2^32 (wrap at 32'hFFFF_FFFC -> 0).
  - accept with next_pc[1:0]!=2'b00 -> FAULT; pc_o takes the offending value.
  - accept otherwise -> pc_o=next_pc, instr_valid_o=0, -> WAIT directly. Back-to-back accept-to-request costs 1 cycle.
- branch_taken_i/branch_target_i are ignored outside HOLD accept cycles.
- FAULT: terminal until reset. fault_o=1, imem_req_o=0, instr_valid_o=0, pc_o frozen at the faulting address.
- Latency: request-to-valid = ack cycle + 1. Minimum instruction period with zero-wait memory (ack in first WAIT cycle) and ready held high = 2 cycles.
- opcode_o is always combinationally equal to instr_o[6:0], with no separate register.

Decomposition:
- fetch_pkg: state encoding (FETCH=2'd0, WAIT=2'd1, HOLD=2'd2, FAULT=2'd3), NOP_INSTR=32'h0000_0013, PC_INC=32'd4.
- One natural sub-module: fetch_timeout_counter, an 8-bit up-counter with clear, enable and terminal-count compare against TIMEOUT_CYCLES-1.
- PC register, next-PC mux and FSM stay in the top module.

Test Plan:
- Reset release, memory acks in first WAIT cycle with rdata=32'h0000_0033, ready=1 -> imem_addr_o=32'h0040_0000; instr_valid_o high one cycle after ack; opcode_o=7'b0110011; next request at 32'h0040_0004.
- Consumer holds ready=0 for 5 cycles -> instr_o/pc_o unchanged, no new imem_req_o; accept on cycle 6 -> pc_o=32'h0040_0004.
- Accept with branch_taken_i=1, target=32'h0040_0100 -> next imem_addr_o=32'h0040_0100. Repeat with target=32'h0040_0102 -> fault_o=1, pc_o=32'h0040_0102, imem_req_o stays 0.
- Memory never acks (TIMEOUT_CYCLES=16) -> fault_o rises after 16 WAIT cycles. ack and err together on another run -> FAULT, instr_valid_o stays 0.
- RESET_PC=32'hFFFF_FFFC, one accept without branch -> next fetch address 32'h0000_0000.
- reset asserted mid-WAIT -> imem_req_o=0 the same cycle; after release, a fresh fetch from RESET_PC with instr_o=NOP until the first ack.
